board_renderer: RTL and testbench

//  Pixel generator directly downstream of the VGA sync/timing block. Consumes its CounterX/CounterY/inDisplayArea
//  and produces 8-bit RGB for the 7x6 connect-four board, discs and blinking drop cursor.

---
 rtl/connect_four_pkg.sv | 37 +++
 rtl/board_store.sv | 52 +++++
 rtl/board_renderer.sv | 148 ++++++++++++++
 tb/tb_board_renderer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect_four_pkg.sv
// Shared geometry, cell encodings and palette for the connect-four pixel renderer.
package connect_four_pkg;

    localparam int BOARD_COLS = 7;
    localparam int BOARD_ROWS = 6;
    localparam int NUM_CELLS  = BOARD_COLS * BOARD_ROWS;

    localparam logic [9:0] SWAP_LINE = 10'd480;
    localparam logic [9:0] STRIP_Y0  = 10'd8;
    localparam logic [9:0] STRIP_Y1  = 10'd39;

    typedef enum logic [1:0] {
        CELL_EMPTY  = 2'd0,
        CELL_RED    = 2'd1,
        CELL_YELLOW = 2'd2,
        CELL_RSVD   = 2'd3
    } cell_t;

    localparam logic [7:0] RGB_BLACK  = 8'h00;
    localparam logic [7:0] RGB_RED    = 8'hE0;
    localparam logic [7:0] RGB_YELLOW = 8'hFC;
    localparam logic [7:0] RGB_BLUE   = 8'h03;

    function automatic logic [7:0] cell_rgb(input cell_t c);
        case (c)
            CELL_RED:    return RGB_RED;
            CELL_YELLOW: return RGB_YELLOW;
            default:     return RGB_BLACK;
        endcase
    endfunction

    // Row-major flat index; out-of-range coordinates must be masked by the caller.
    function automatic logic [5:0] cell_index(input logic [2:0] col, input logic [2:0] row);
        return 6'(row) * 6'd7 + 6'(col);
    endfunction

endpackage

// File: rtl/board_store.sv
// Working board written by game logic plus a shadow copy that the renderer reads;
// the shadow is refreshed only on the once-per-frame swap strobe.
module board_store
    import connect_four_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_col,
    input  logic [2:0] wr_row,
    input  logic [1:0] wr_val,
    input  logic       clear,
    input  logic       swap,
    input  logic [2:0] rd_col,
    input  logic [2:0] rd_row,
    output logic [1:0] rd_cell
);

    logic [2*NUM_CELLS-1:0] r_work;
    logic [2*NUM_CELLS-1:0] r_shadow;

    logic       w_wr_ok;
    logic       w_rd_ok;
    logic [6:0] w_wr_bit;
    logic [6:0] w_rd_bit;
    logic [1:0] w_wr_data;

    assign w_wr_ok   = wr_en && (wr_col < 3'(BOARD_COLS)) && (wr_row < 3'(BOARD_ROWS));
    assign w_rd_ok   = (rd_col < 3'(BOARD_COLS)) && (rd_row < 3'(BOARD_ROWS));
    assign w_wr_bit  = {cell_index(wr_col, wr_row), 1'b0};
    assign w_rd_bit  = {cell_index(rd_col, rd_row), 1'b0};
    assign w_wr_data = (wr_val == 2'(CELL_RSVD)) ? 2'(CELL_EMPTY) : wr_val;

    // Swap samples r_work before this edge's write/clear lands, so a coincident
    // update shows up one frame later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work   <= '0;
            r_shadow <= '0;
        end else begin
            if (swap)
                r_shadow <= r_work;
            if (clear)
                r_work <= '0;
            else if (w_wr_ok)
                r_work[w_wr_bit +: 2] <= w_wr_data;
        end
    end

    assign rd_cell = w_rd_ok ? r_shadow[w_rd_bit +: 2] : 2'(CELL_EMPTY);

endmodule

// File: rtl/board_renderer.sv
// Two-stage pixel pipeline turning VGA counters into RGB for the board, discs and
// blinking drop cursor; also owns the frame counter and the shadow-swap strobe.
module board_renderer
    import connect_four_pkg::*;
#(
    parameter int BOARD_X0  = 96,
    parameter int BOARD_Y0  = 48,
    parameter int CELL_SIZE = 64,
    parameter int DISC_R2   = 784,
    parameter int BLINK_BIT = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    input  logic       inDisplayArea,
    input  logic       wr_en,
    input  logic [2:0] wr_col,
    input  logic [2:0] wr_row,
    input  logic [1:0] wr_val,
    input  logic       clear,
    input  logic [2:0] cursor_col,
    input  logic       player,
    output logic [7:0] rgb,
    output logic       frame_tick
);

    localparam int CELL_BITS = $clog2(CELL_SIZE);
    localparam int SUM_W     = 2 * CELL_BITS + 1;
    localparam logic [9:0] X_LO   = 10'(BOARD_X0);
    localparam logic [9:0] Y_LO   = 10'(BOARD_Y0);
    localparam logic [9:0] X_SPAN = 10'(BOARD_COLS * CELL_SIZE);
    localparam logic [9:0] Y_SPAN = 10'(BOARD_ROWS * CELL_SIZE);
    localparam logic signed [CELL_BITS:0] HALF = (CELL_BITS + 1)'(CELL_SIZE / 2);

    logic [9:0] w_rel_x;
    logic [9:0] w_rel_y;
    logic       w_in_xrange;
    logic       w_swap;

    logic                 r_s1_disp;
    logic                 r_s1_in_board;
    logic                 r_s1_in_strip;
    logic [2:0]           r_s1_col;
    logic [2:0]           r_s1_row;
    logic [CELL_BITS-1:0] r_s1_dx;
    logic [CELL_BITS-1:0] r_s1_dy;

    logic [4:0] r_frame_cnt;
    logic       r_frame_tick;
    logic [7:0] r_rgb;

    // Unsigned wrap of the relative coordinate makes one compare cover both edges.
    assign w_rel_x     = CounterX - X_LO;
    assign w_rel_y     = CounterY - Y_LO;
    assign w_in_xrange = w_rel_x < X_SPAN;
    assign w_swap      = (CounterX == 10'd0) && (CounterY == SWAP_LINE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_disp     <= 1'b0;
            r_s1_in_board <= 1'b0;
            r_s1_in_strip <= 1'b0;
            r_s1_col      <= '0;
            r_s1_row      <= '0;
            r_s1_dx       <= '0;
            r_s1_dy       <= '0;
        end else begin
            r_s1_disp     <= inDisplayArea;
            r_s1_in_board <= w_in_xrange && (w_rel_y < Y_SPAN);
            r_s1_in_strip <= w_in_xrange && (CounterY >= STRIP_Y0) && (CounterY <= STRIP_Y1);
            r_s1_col      <= w_rel_x[CELL_BITS +: 3];
            r_s1_row      <= w_rel_y[CELL_BITS +: 3];
            r_s1_dx       <= w_rel_x[CELL_BITS-1:0];
            r_s1_dy       <= w_rel_y[CELL_BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_swap;
            if (w_swap)
                r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    logic [1:0] w_cell;

    board_store u_store (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_col  (wr_col),
        .wr_row  (wr_row),
        .wr_val  (wr_val),
        .clear   (clear),
        .swap    (w_swap),
        .rd_col  (r_s1_col),
        .rd_row  (r_s1_row),
        .rd_cell (w_cell)
    );

    logic signed [CELL_BITS:0] w_ddx;
    logic signed [CELL_BITS:0] w_ddy;
    logic signed [SUM_W-1:0]   w_ex_x;
    logic signed [SUM_W-1:0]   w_ex_y;
    logic signed [SUM_W-1:0]   w_sq_x;
    logic signed [SUM_W-1:0]   w_sq_y;
    logic [SUM_W-1:0]          w_dist2;
    logic                      w_disc;
    logic                      w_cursor_hit;
    logic [7:0]                w_rgb;

    assign w_ddx   = $signed({1'b0, r_s1_dx}) - HALF;
    assign w_ddy   = $signed({1'b0, r_s1_dy}) - HALF;
    assign w_ex_x  = {{(SUM_W - CELL_BITS - 1){w_ddx[CELL_BITS]}}, w_ddx};
    assign w_ex_y  = {{(SUM_W - CELL_BITS - 1){w_ddy[CELL_BITS]}}, w_ddy};
    assign w_sq_x  = w_ex_x * w_ex_x;
    assign w_sq_y  = w_ex_y * w_ex_y;
    assign w_dist2 = $unsigned(w_sq_x) + $unsigned(w_sq_y);
    assign w_disc  = w_dist2 < SUM_W'(DISC_R2);

    assign w_cursor_hit = (cursor_col < 3'(BOARD_COLS)) && (r_s1_col == cursor_col);

    always_comb begin
        w_rgb = RGB_BLACK;
        if (r_s1_disp) begin
            if (r_s1_in_strip && w_cursor_hit && w_disc && !r_frame_cnt[BLINK_BIT])
                w_rgb = player ? RGB_YELLOW : RGB_RED;
            else if (r_s1_in_board)
                w_rgb = w_disc ? cell_rgb(cell_t'(w_cell)) : RGB_BLUE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rgb <= RGB_BLACK;
        else
            r_rgb <= w_rgb;
    end

    assign rgb        = r_rgb;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: drives counters directly, scoreboards rgb two clocks later
// against a behavioural model or hand-derived probe constants.
module tb_board_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic       inDisplayArea;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [2:0] wr_row;
    logic [1:0] wr_val;
    logic       clear;
    logic [2:0] cursor_col;
    logic       player;
    logic [7:0] rgb;
    logic       frame_tick;

    board_renderer dut (
        .clk           (clk),
        .reset         (reset),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .inDisplayArea (inDisplayArea),
        .wr_en         (wr_en),
        .wr_col        (wr_col),
        .wr_row        (wr_row),
        .wr_val        (wr_val),
        .clear         (clear),
        .cursor_col    (cursor_col),
        .player        (player),
        .rgb           (rgb),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] rgb; int x; int y; } sb_t;
    typedef struct { int phase; int x; int y; logic [7:0] rgb; } probe_t;

    sb_t    sb_q[$];
    probe_t tbl[$];

    int n_checks = 0;
    int n_err    = 0;
    int n_ticks  = 0;
    logic exp_tick;

    logic [1:0] m_work[6][7];
    logic [1:0] m_shadow[6][7];
    int         m_frame;

    logic       req_we, req_clr;
    logic [2:0] req_col, req_row;
    logic [1:0] req_val;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_work[r, c]) begin
            m_work[r][c]   = 2'd0;
            m_shadow[r][c] = 2'd0;
        end
        m_frame  = 0;
        exp_tick = 1'b0;
    endtask

    function automatic logic [7:0] model_rgb(input int x, input int y);
        int bx, by, dx, dy, d2;
        logic [1:0] c;
        if (x >= 640 || y >= 480) return 8'h00;
        bx = x - 96;
        by = y - 48;
        dx = bx & 63;
        dy = by & 63;
        d2 = (dx - 32) * (dx - 32) + (dy - 32) * (dy - 32);
        if (y >= 8 && y <= 39 && x >= 96 && x < 544 && int'(cursor_col) == bx / 64
            && d2 < 784 && (m_frame & 16) == 0)
            return player ? 8'hFC : 8'hE0;
        if (x >= 96 && x < 544 && y >= 48 && y < 432) begin
            if (d2 >= 784) return 8'h03;
            c = m_shadow[by / 64][bx / 64];
            return (c == 2'd1) ? 8'hE0 : (c == 2'd2) ? 8'hFC : 8'h00;
        end
        return 8'h00;
    endfunction

    // One pixel per call: retire the result driven two calls ago, then drive a new one.
    task automatic pix(input int x, input int y, input bit use_tbl = 1'b0,
                       input logic [7:0] tbl_rgb = 8'h00);
        sb_t e;
        bit  sw;
        @(negedge clk);
        check("frame_tick", {7'd0, frame_tick}, {7'd0, exp_tick});
        if (frame_tick) n_ticks++;
        if (sb_q.size() == 2) begin
            e = sb_q.pop_front();
            check($sformatf("rgb(%0d,%0d)", e.x, e.y), rgb, e.rgb);
        end
        CounterX      = 10'(x);
        CounterY      = 10'(y);
        inDisplayArea = (x < 640 && y < 480);
        wr_en  = req_we;
        wr_col = req_col;
        wr_row = req_row;
        wr_val = req_val;
        clear  = req_clr;
        req_we  = 1'b0;
        req_clr = 1'b0;
        e.x   = x;
        e.y   = y;
        e.rgb = use_tbl ? tbl_rgb : model_rgb(x, y);
        sb_q.push_back(e);
        sw = (x == 0 && y == 480);
        if (sw) begin
            m_shadow = m_work;
            m_frame  = (m_frame + 1) % 32;
        end
        if (clear) begin
            foreach (m_work[r, c]) m_work[r][c] = 2'd0;
        end else if (wr_en && wr_col < 3'd7 && wr_row < 3'd6) begin
            m_work[wr_row][wr_col] = (wr_val == 2'd3) ? 2'd0 : wr_val;
        end
        exp_tick = sw;
    endtask

    task automatic flush();
        pix(700, 500);
        pix(700, 500);
    endtask

    task automatic swap();
        pix(0, 480);
    endtask

    task automatic wr(input int c, input int r, input int v, input bit clr = 1'b0);
        req_we  = 1'b1;
        req_col = 3'(c);
        req_row = 3'(r);
        req_val = 2'(v);
        req_clr = clr;
        pix(700, 500);
    endtask

    task automatic run_probes(input int ph);
        foreach (tbl[i])
            if (tbl[i].phase == ph) pix(tbl[i].x, tbl[i].y, 1'b1, tbl[i].rgb);
        flush();
    endtask

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{0, 128,  80, 8'h00});
        tbl.push_back('{0, 100,  50, 8'h03});
        tbl.push_back('{0, 600, 100, 8'h00});
        tbl.push_back('{0, 320,  24, 8'h00});
        tbl.push_back('{0,  95,  80, 8'h00});
        tbl.push_back('{0,  96,  80, 8'h03});
        tbl.push_back('{0, 543,  80, 8'h03});
        tbl.push_back('{0, 544,  80, 8'h00});
        tbl.push_back('{0, 128, 431, 8'h03});
        tbl.push_back('{0, 128, 432, 8'h00});
        tbl.push_back('{1, 128,  80, 8'h00});
        tbl.push_back('{2, 128,  80, 8'hE0});
        tbl.push_back('{2, 130,  82, 8'hE0});
        tbl.push_back('{2, 128, 144, 8'h00});
        tbl.push_back('{2, 100,  50, 8'h03});
        tbl.push_back('{3, 512, 400, 8'h00});
        tbl.push_back('{3, 128, 144, 8'h00});
        tbl.push_back('{4, 512, 400, 8'hFC});
        tbl.push_back('{4, 128, 144, 8'h00});
        tbl.push_back('{4, 128,  80, 8'hE0});
        tbl.push_back('{5, 320, 208, 8'h00});
        tbl.push_back('{5, 128,  80, 8'h00});
        tbl.push_back('{5, 512, 400, 8'h00});
        tbl.push_back('{6, 320,  24, 8'hFC});
        tbl.push_back('{6, 320,   8, 8'hFC});
        tbl.push_back('{6, 320,   7, 8'h00});
        tbl.push_back('{6, 320,  40, 8'h00});
        tbl.push_back('{6, 256,  24, 8'h00});
        tbl.push_back('{6, 288,  24, 8'h00});
        tbl.push_back('{7, 320,  24, 8'h00});
        tbl.push_back('{8, 320,  24, 8'hE0});
        tbl.push_back('{9, 320,  24, 8'h00});
        tbl.push_back('{9, 128,  80, 8'hE0});
        tbl.push_back('{10, 128, 80, 8'h00});
        tbl.push_back('{10, 320, 24, 8'hFC});

        reset = 1'b1;
        CounterX = 10'd700;
        CounterY = 10'd500;
        inDisplayArea = 1'b0;
        wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_val = '0; clear = 1'b0;
        req_we = 1'b0; req_clr = 1'b0; req_col = '0; req_row = '0; req_val = '0;
        cursor_col = 3'd7;
        player = 1'b0;
        model_reset();
        #1;
        check("reset_rgb", rgb, 8'h00);
        check("reset_tick", {7'd0, frame_tick}, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Coarse sweep of a whole frame on an empty board, including the swap line.
        for (int y = 0; y < 521; y += 8)
            for (int x = 0; x < 800; x += 8)
                pix(x, y);
        flush();
        run_probes(0);

        wr(0, 0, 1);
        run_probes(1);
        swap();
        run_probes(2);

        wr(7, 0, 1);
        req_we = 1'b1; req_col = 3'd6; req_row = 3'd5; req_val = 2'd2;
        swap();
        run_probes(3);
        swap();
        run_probes(4);

        wr(3, 2, 1, 1'b1);
        swap();
        run_probes(5);

        cursor_col = 3'd3;
        player = 1'b1;
        run_probes(6);
        while (m_frame != 16) swap();
        run_probes(7);
        player = 1'b0;
        while (m_frame != 0) swap();
        run_probes(8);

        cursor_col = 3'd7;
        wr(0, 0, 1);
        swap();
        run_probes(9);

        // Asynchronous reset in the middle of a visible line.
        pix(100, 200);
        pix(100, 200);
        pix(100, 200);
        @(negedge clk);
        check("rgb_pre_reset", rgb, 8'h03);
        #1 reset = 1'b1;
        #1;
        check("rgb_async_reset", rgb, 8'h00);
        check("tick_async_reset", {7'd0, frame_tick}, 8'h00);
        sb_q.delete();
        model_reset();
        cursor_col = 3'd3;
        player = 1'b1;
        repeat (2) @(negedge clk);
        check("rgb_held_reset", rgb, 8'h00);
        reset = 1'b0;
        swap();
        run_probes(10);

        n_ticks = 0;
        for (int y = 0; y < 521; y++) begin
            pix(0, y);
            pix(320, y);
        end
        check_int("ticks_one_frame", n_ticks, 1);
        for (int y = 0; y < 521; y++) begin
            pix(0, y);
            pix(320, y);
        end
        flush();
        check_int("ticks_two_frames", n_ticks, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
